// File: rtl/seq_subfsm_param.sv
// seq_subfsm_param: child sequence detector that counts matches and hands back.
// Define SEQ_SUBFSM_TIMEOUT_EN to add the no-match timeout handoff.
module seq_subfsm_param #(
  parameter int unsigned          PAT_LEN     = 3,
  parameter logic [PAT_LEN-1:0]   PATTERN     = 3'b110,
  parameter int unsigned          OVERLAP     = 1,
  parameter int unsigned          MATCH_LIMIT = 2,
  parameter int unsigned          TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       grant,
  input  logic       in,
  output logic       hit_out,
  output logic       done_out,
  output logic [7:0] match_cnt,
  output logic       timeout_out
);

  typedef enum logic [1:0] {IDLE, RUN, HANDOFF} state_t;

  localparam int unsigned   VW    = $clog2(PAT_LEN + 1);
  localparam logic [VW-1:0] VFULL = VW'(PAT_LEN);
  localparam logic [7:0]    LIMIT = 8'(MATCH_LIMIT);

  state_t             state, state_n;
  logic [PAT_LEN-2:0] hist, hist_n, hist_b;
  logic [PAT_LEN-1:0] win_s;
  logic [VW-1:0]      val, val_n, val_b, val_s;
  logic [7:0]         cnt, cnt_n, cnt_inc;
  logic               hit_q, hit_n;
  logic               done_q, done_n;
  logic               running, sample, match;

`ifdef SEQ_SUBFSM_TIMEOUT_EN
  localparam int unsigned   TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TFULL = TW'(TIMEOUT_CYC);

  logic [TW-1:0] tcnt, tcnt_n, tcnt_inc;
  logic          tmo_q, tmo_n;
`endif

  always_comb begin
    running = (state == RUN);
    sample  = grant && (state != HANDOFF);
    // a fresh run starts from an empty history
    hist_b  = running ? hist : '0;
    val_b   = running ? val : '0;
    win_s   = {hist_b, in};
    val_s   = (val_b == VFULL) ? VFULL : val_b + 1'b1;
    match   = (val_s == VFULL) && (win_s == PATTERN);
    cnt_inc = cnt + 8'd1;

    state_n = state;
    hist_n  = hist;
    val_n   = val;
    cnt_n   = cnt;
    hit_n   = 1'b0;
    done_n  = 1'b0;
`ifdef SEQ_SUBFSM_TIMEOUT_EN
    tcnt_inc = tcnt + 1'b1;
    tcnt_n   = tcnt;
    tmo_n    = 1'b0;
`endif

    unique case (1'b1)
      !grant: begin
        state_n = IDLE;
        hist_n  = '0;
        val_n   = '0;
        cnt_n   = '0;
`ifdef SEQ_SUBFSM_TIMEOUT_EN
        tcnt_n  = '0;
`endif
      end
      sample: begin
        state_n = RUN;
        hist_n  = win_s[PAT_LEN-2:0];
        val_n   = val_s;
`ifdef SEQ_SUBFSM_TIMEOUT_EN
        tcnt_n  = tcnt_inc;
`endif
        if (match) begin
          hit_n = 1'b1;
          cnt_n = cnt_inc;
`ifdef SEQ_SUBFSM_TIMEOUT_EN
          tcnt_n = '0;
`endif
          if (OVERLAP == 0) val_n = '0;
          if (cnt_inc == LIMIT) begin
            done_n  = 1'b1;
            state_n = HANDOFF;
          end
        end
`ifdef SEQ_SUBFSM_TIMEOUT_EN
        else if (tcnt_inc == TFULL) begin
          done_n  = 1'b1;
          tmo_n   = 1'b1;
          tcnt_n  = '0;
          state_n = HANDOFF;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hist   <= '0;
      val    <= '0;
      cnt    <= '0;
      hit_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      hist   <= hist_n;
      val    <= val_n;
      cnt    <= cnt_n;
      hit_q  <= hit_n;
      done_q <= done_n;
    end
  end

`ifdef SEQ_SUBFSM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      tmo_q <= 1'b0;
    end else begin
      tcnt  <= tcnt_n;
      tmo_q <= tmo_n;
    end
  end

  assign timeout_out = tmo_q;
`else
  assign timeout_out = 1'b0;
`endif

  assign hit_out   = hit_q;
  assign done_out  = done_q;
  assign match_cnt = cnt;

endmodule
